// File: rtl/axi_ram_responder.sv
// axi_ram_responder: single-port 64-bit RAM behind a simple level/pulse request protocol.
// Reads return data READ_LAT cycles after acceptance; writes ack in one cycle and respond
// in the next. Optional address range checking is enabled with RAM_RESP_RANGE_CHECK_EN.
module axi_ram_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned READ_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_ren_i,
    input  logic [31:0] ram_raddr_i,
    output logic [63:0] ram_rdata_o,
    output logic        ram_rready_o,
    input  logic        ram_wen_i,
    input  logic [31:0] ram_waddr_i,
    input  logic [63:0] ram_wdata_i,
    input  logic [63:0] ram_wmask_i,
    output logic        ram_wready_o,
    output logic        ram_bvalid_o,
    output logic        resp_err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdResp,
        StWrAck,
        StWrResp
    } state_e;

    localparam logic [63:0] ErrData = 64'hDEAD_BEEF_DEAD_BEEF;

    state_e                  r_state;
    logic [3:0]              r_cnt;
    logic [31:0]             r_addr;
    logic [63:0]             r_wdata;
    logic [63:0]             r_wmask;
    logic                    r_wbad;
    logic [63:0]             r_rdata;
    logic                    r_rready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic                    r_err;
    logic [63:0]             r_mem [0:(1 << DEPTH_LOG2) - 1];

    logic [31:0]             w_rd_addr;
    logic [DEPTH_LOG2-1:0]   w_rd_idx;
    logic [DEPTH_LOG2-1:0]   w_wr_idx;
    logic                    w_rd_bad;
    logic                    w_wr_bad;
    logic [63:0]             w_rd_data;

    // With READ_LAT=1 the word is fetched on the accepting edge, before r_addr is loaded.
    assign w_rd_addr = (r_state == StIdle) ? ram_raddr_i : r_addr;
    assign w_rd_idx  = DEPTH_LOG2'((w_rd_addr - BASE_ADDR) >> 3);
    assign w_wr_idx  = DEPTH_LOG2'((r_addr - BASE_ADDR) >> 3);

`ifdef RAM_RESP_RANGE_CHECK_EN
    // Offset compare in 33 bits so addresses below BASE_ADDR wrap to huge offsets.
    assign w_rd_bad = {1'b0, w_rd_addr - BASE_ADDR} >= (33'd8 << DEPTH_LOG2);
    assign w_wr_bad = {1'b0, ram_waddr_i - BASE_ADDR} >= (33'd8 << DEPTH_LOG2);
`else
    assign w_rd_bad = 1'b0;
    assign w_wr_bad = 1'b0;
`endif

    assign w_rd_data = w_rd_bad ? ErrData : r_mem[w_rd_idx];

    // Handshake FSM; every output is a register loaded on the edge entering its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= 4'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 64'd0;
            r_wmask  <= 64'd0;
            r_wbad   <= 1'b0;
            r_rdata  <= 64'd0;
            r_rready <= 1'b0;
            r_wready <= 1'b0;
            r_bvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rdata  <= 64'd0;
            r_rready <= 1'b0;
            r_wready <= 1'b0;
            r_bvalid <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                StIdle: begin
                    // Read wins a tie; a held write is picked up on a later idle cycle.
                    if (ram_ren_i) begin
                        r_addr <= ram_raddr_i;
                        if (READ_LAT == 1) begin
                            r_state  <= StRdResp;
                            r_rready <= 1'b1;
                            r_rdata  <= w_rd_data;
                            r_err    <= w_rd_bad;
                        end else begin
                            r_state <= StRdWait;
                            r_cnt   <= 4'(READ_LAT - 1);
                        end
                    end else if (ram_wen_i) begin
                        r_addr   <= ram_waddr_i;
                        r_wdata  <= ram_wdata_i;
                        r_wmask  <= ram_wmask_i;
                        r_wbad   <= w_wr_bad;
                        r_state  <= StWrAck;
                        r_wready <= 1'b1;
                    end
                end
                StRdWait: begin
                    if (r_cnt == 4'd1) begin
                        r_state  <= StRdResp;
                        r_rready <= 1'b1;
                        r_rdata  <= w_rd_data;
                        r_err    <= w_rd_bad;
                    end
                    r_cnt <= r_cnt - 4'd1;
                end
                StRdResp: r_state <= StIdle;
                StWrAck: begin
                    r_state  <= StWrResp;
                    r_bvalid <= 1'b1;
                    r_err    <= r_wbad;
                end
                StWrResp: r_state <= StIdle;
                default:  r_state <= StIdle;
            endcase
        end
    end

    // Masked write at the end of the ack cycle; storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && r_state == StWrAck && !r_wbad) begin
            r_mem[w_wr_idx] <= (r_mem[w_wr_idx] & ~r_wmask) | (r_wdata & r_wmask);
        end
    end

    assign ram_rdata_o  = r_rdata;
    assign ram_rready_o = r_rready;
    assign ram_wready_o = r_wready;
    assign ram_bvalid_o = r_bvalid;
    assign resp_err_o   = r_err;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed bench for axi_ram_responder (default parameters, READ_LAT=2).
// Out-of-range checks follow RAM_RESP_RANGE_CHECK_EN when defined.
module tb_axi_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren, wen;
    logic [31:0] raddr, waddr;
    logic [63:0] wdata, wmask;
    logic [63:0] rdata;
    logic        rready, wready, bvalid, err;

    int n_tests = 0;
    int n_fail  = 0;

    axi_ram_responder dut (
        .clk          (clk),
        .rst          (rst),
        .ram_ren_i    (ren),
        .ram_raddr_i  (raddr),
        .ram_rdata_o  (rdata),
        .ram_rready_o (rready),
        .ram_wen_i    (wen),
        .ram_waddr_i  (waddr),
        .ram_wdata_i  (wdata),
        .ram_wmask_i  (wmask),
        .ram_wready_o (wready),
        .ram_bvalid_o (bvalid),
        .resp_err_o   (err)
    );

    always #5 clk = ~clk;

    // Packed view of every output: {rready, wready, bvalid, err, rdata}
    function automatic logic [67:0] ex(input bit rr, input bit wr, input bit bv, input bit er,
                                       input logic [63:0] d);
        return {rr, wr, bv, er, d};
    endfunction

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample just after the edge, and check pulse exclusivity.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("pulse_excl", {67'd0, $onehot0({rready, wready, bvalid})}, 68'd1);
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [63:0] d,
                            input logic [63:0] m, input bit exp_err);
        wen = 1'b1; waddr = a; wdata = d; wmask = m;
        tick();
        chk({tag, "_wready"}, {rready, wready, bvalid, err, rdata}, ex(0, 1, 0, 0, 64'd0));
        // Scramble inputs after acceptance; they must be ignored.
        wen = 1'b0; waddr = ~a; wdata = ~d; wmask = ~m;
        tick();
        chk({tag, "_bvalid"}, {rready, wready, bvalid, err, rdata}, ex(0, 0, 1, exp_err, 64'd0));
        tick();
        chk({tag, "_idle"}, {rready, wready, bvalid, err, rdata}, ex(0, 0, 0, 0, 64'd0));
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [63:0] d,
                           input bit exp_err);
        ren = 1'b1; raddr = a;
        tick();
        chk({tag, "_wait"}, {rready, wready, bvalid, err, rdata}, ex(0, 0, 0, 0, 64'd0));
        raddr = ~a;
        tick();
        chk({tag, "_rready"}, {rready, wready, bvalid, err, rdata}, ex(1, 0, 0, exp_err, d));
        ren = 1'b0;
        tick();
        chk({tag, "_idle"}, {rready, wready, bvalid, err, rdata}, ex(0, 0, 0, 0, 64'd0));
    endtask

    initial begin
        rst = 1'b1; ren = 1'b0; wen = 1'b0;
        raddr = 32'd0; waddr = 32'd0; wdata = 64'd0; wmask = 64'd0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_idle", {rready, wready, bvalid, err, rdata}, ex(0, 0, 0, 0, 64'd0));
        end

        // Full write then read-back, issued back to back.
        do_write("wr_full", 32'h8000_0010, 64'h1122_3344_5566_7788, '1, 1'b0);
        do_read("rd_full", 32'h8000_0010, 64'h1122_3344_5566_7788, 1'b0);

        // Partial masked write; addr[2:0] ignored.
        do_write("wr_part", 32'h8000_0015, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000, 1'b0);
        do_read("rd_part", 32'h8000_0010, 64'h1122_3344_FFFF_7788, 1'b0);

        // Seed word 0 with a known value.
        do_write("wr_w0", 32'h8000_0000, 64'hA5A5_A5A5_5A5A_5A5A, '1, 1'b0);

        // Simultaneous read and write: read first, write afterwards.
        ren = 1'b1; raddr = 32'h8000_0000;
        wen = 1'b1; waddr = 32'h8000_0008; wdata = 64'h0BAD_F00D_CAFE_0001; wmask = '1;
        tick();
        chk("coll_c1", {rready, wready, bvalid, err, rdata}, ex(0, 0, 0, 0, 64'd0));
        tick();
        chk("coll_rready", {rready, wready, bvalid, err, rdata},
            ex(1, 0, 0, 0, 64'hA5A5_A5A5_5A5A_5A5A));
        ren = 1'b0;
        tick();
        chk("coll_c3", {rready, wready, bvalid, err, rdata}, ex(0, 0, 0, 0, 64'd0));
        tick();
        chk("coll_wready", {rready, wready, bvalid, err, rdata}, ex(0, 1, 0, 0, 64'd0));
        wen = 1'b0;
        tick();
        chk("coll_bvalid", {rready, wready, bvalid, err, rdata}, ex(0, 0, 1, 0, 64'd0));
        tick();
        chk("coll_idle", {rready, wready, bvalid, err, rdata}, ex(0, 0, 0, 0, 64'd0));
        do_read("coll_rdback", 32'h8000_0008, 64'h0BAD_F00D_CAFE_0001, 1'b0);

        // Reset on the accepting edge of a write: no handshake, memory untouched.
        wen = 1'b1; waddr = 32'h8000_0010; wdata = 64'd0; wmask = '1; rst = 1'b1;
        tick();
        chk("rstwr_c1", {rready, wready, bvalid, err, rdata}, ex(0, 0, 0, 0, 64'd0));
        wen = 1'b0; rst = 1'b0;
        tick();
        chk("rstwr_c2", {rready, wready, bvalid, err, rdata}, ex(0, 0, 0, 0, 64'd0));
        do_read("rstwr_rd", 32'h8000_0010, 64'h1122_3344_FFFF_7788, 1'b0);

        // Reset during the read wait cycle: no rready pulse.
        ren = 1'b1; raddr = 32'h8000_0000;
        tick();
        rst = 1'b1; ren = 1'b0;
        tick();
        chk("rstrd_c2", {rready, wready, bvalid, err, rdata}, ex(0, 0, 0, 0, 64'd0));
        rst = 1'b0;
        tick();
        chk("rstrd_c3", {rready, wready, bvalid, err, rdata}, ex(0, 0, 0, 0, 64'd0));

`ifdef RAM_RESP_RANGE_CHECK_EN
        do_read("oor_rd", 32'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
        do_write("oor_wr", 32'h8000_8000, 64'h1234_5678_9ABC_DEF0, '1, 1'b1);
        do_read("oor_w0", 32'h8000_0000, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0);
`else
        // Without range checking, addresses alias modulo the array size.
        do_write("alias_wr", 32'h8000_8000, 64'h1234_5678_9ABC_DEF0, '1, 1'b0);
        do_read("alias_w0", 32'h8000_0000, 64'h1234_5678_9ABC_DEF0, 1'b0);
        do_write("alias_top", 32'h8000_7FF8, 64'h0F0F_0F0F_0F0F_0F0F, '1, 1'b0);
        do_read("alias_low", 32'h7FFF_FFF8, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ram_responder.md
AXI_RAM_RESPONDER -- requirements
Module: axi_ram_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning the byte address of memory word 0.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the number of 64-bit words.
REQ-003 The block SHALL have parameter READ_LAT, default 2, legal 1..15, meaning cycles from read accept to rready_o.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ram_ren_i  input  1  read request level, held by the initiator until ram_rready_o.
REQ-007 ram_raddr_i  input  32  read byte address.
REQ-008 ram_rdata_o  output  64  read data, valid only while ram_rready_o=1.
REQ-009 ram_rready_o  output  1  one-cycle read-data-valid pulse.
REQ-010 ram_wen_i  input  1  write request level, held until ram_wready_o.
REQ-011 ram_waddr_i  input  32  write byte address.
REQ-012 ram_wdata_i  input  64  write data.
REQ-013 ram_wmask_i  input  64  per-bit write enable; 1 = bit written.
REQ-014 ram_wready_o  output  1  one-cycle write-accepted pulse.
REQ-015 ram_bvalid_o  output  1  one-cycle write-response pulse.
REQ-016 resp_err_o  output  1  one-cycle out-of-range pulse, coincident with rready_o or bvalid_o.

Function
REQ-017 Storage SHALL be 2^DEPTH_LOG2 words of 64 bits; word index = (addr - BASE_ADDR)[DEPTH_LOG2+2:3]; addr[2:0] ignored.
REQ-018 FSM states SHALL be IDLE, RD_WAIT, RD_RESP, WR_ACK, WR_RESP.
REQ-019 Requests SHALL be sampled only in IDLE; address, data and mask are latched at the accepting edge; input changes afterwards are ignored.
REQ-020 IDLE with ram_ren_i=1 SHALL go to RD_WAIT (or to RD_RESP if READ_LAT=1), loading a 4-bit latency counter.
REQ-021 ram_rready_o SHALL be 1 for exactly one cycle, READ_LAT cycles after the accepting cycle, with ram_rdata_o = the word at the latched address; the FSM then returns to IDLE.
REQ-022 ram_rdata_o SHALL be 0 whenever ram_rready_o=0.
REQ-023 IDLE with ram_wen_i=1 and ram_ren_i=0 SHALL go to WR_ACK.
REQ-024 In WR_ACK, ram_wready_o=1 for one cycle; at the end of that cycle mem = (mem & ~mask) | (wdata & mask).
REQ-025 WR_RESP SHALL follow WR_ACK with ram_bvalid_o=1 for one cycle, then return to IDLE.
REQ-026 When ram_ren_i and ram_wen_i are both 1 in IDLE, the read SHALL win; the write stays pending and is accepted in the first IDLE cycle after the read completes.
REQ-027 A new request SHALL be acceptable in the cycle immediately after rready_o or bvalid_o, giving back-to-back throughput: read every READ_LAT+1 cycles, write every 3 cycles.
REQ-028 A read issued after a write's bvalid_o SHALL return the newly written data.
REQ-029 ram_rready_o, ram_wready_o and ram_bvalid_o SHALL be mutually exclusive in every cycle.

Reset
REQ-030 While rst=1 at a clock edge, the FSM SHALL enter IDLE, the counter SHALL clear, and all outputs SHALL be 0 from the next cycle.
REQ-031 Reset mid-operation SHALL abort the transaction with no pulse emitted; a write aborted before the WR_ACK edge SHALL leave memory unchanged.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-033 With macro RAM_RESP_RANGE_CHECK_EN defined, an address outside [BASE_ADDR, BASE_ADDR + 8*2^DEPTH_LOG2) SHALL make the read return 64'hDEAD_BEEF_DEAD_BEEF, drop the write (memory unchanged), keep the full handshake timing, and pulse resp_err_o.
REQ-034 Without RAM_RESP_RANGE_CHECK_EN, out-of-range addresses SHALL alias through the index formula and resp_err_o SHALL be tied to 0.

Verification
REQ-035 Reset, then idle for 5 cycles -> all outputs 0 and state IDLE.
REQ-036 Write 0x8000_0010 data 64'h1122_3344_5566_7788, mask all-ones, then read 0x8000_0010 with READ_LAT=2 -> wready in cycle 1, bvalid in cycle 2; rready exactly 2 cycles after read accept with rdata 64'h1122_3344_5566_7788.
REQ-037 Partial write to the same word: data 64'hFFFF_FFFF_FFFF_FFFF, mask 64'h0000_0000_FFFF_0000, then read -> 64'h1122_3344_FFFF_7788.
REQ-038 ren and wen asserted in the same cycle (read 0x8000_0000, write 0x8000_0008) -> rready first, then wready on the first accept after, then bvalid; no two pulses in the same cycle.
REQ-039 rst asserted in the WR_ACK-pending cycle after a write accept -> no wready/bvalid; a subsequent read of that address returns the old value.
REQ-040 With RAM_RESP_RANGE_CHECK_EN, read 0x7FFF_FFF8 -> rdata 64'hDEAD_BEEF_DEAD_BEEF with resp_err_o=1; write 0x8000_8000 -> bvalid with resp_err_o=1 and word 0 unchanged.
